// File: rtl/tla_merge_unpack_pkg.sv
// tla_merge_unpack_pkg: shared types, defaults and lane-count helpers for the merge unpacker
package tla_merge_unpack_pkg;
   typedef enum logic {IDLE, RUN} state_t;
   localparam int ADC_W_DEF = 14;
   localparam int LEN_W_DEF = 32;
   function automatic int lanes_of(input int word_w, input int smp_w);
      return word_w / smp_w;
   endfunction
   function automatic bit lanes_ok(input int word_w, input int smp_w);
      return smp_w > 0 && word_w >= smp_w && word_w % smp_w == 0;
   endfunction
endpackage

// File: rtl/tla_merge_unpack.sv
// tla_merge_unpack: unpacks merged ADC words into a one-sample-per-cycle capture stream
module tla_merge_unpack
   import tla_merge_unpack_pkg::*;
#(
   parameter int ADC0_0 = ADC_W_DEF,
   parameter int ADC0_1 = ADC0_0 * 4,
   parameter int LDD0_0 = LEN_W_DEF
) (
   input  logic              Gc_clk125,
   input  logic              Gc_rst,
   input  logic              Gc_cap_start,
   input  logic [LDD0_0-1:0] Gc_cap_len,
   input  logic              Gc_cap_abort,
   input  logic [ADC0_1-1:0] Gc_merge_data,
   input  logic              Gc_merge_datv,
   output logic              Gc_merge_datr,
   output logic [ADC0_0-1:0] Gc_smp_data,
   output logic              Gc_smp_valid,
   input  logic              Gc_smp_ready,
   output logic              Gc_smp_last,
   output logic              Gc_cap_busy,
   output logic              Gc_cap_done
);
   localparam int LANES = lanes_of(ADC0_1, ADC0_0);
   localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
   localparam logic [LW-1:0] LANE_MAX = LW'(LANES - 1);
   if (!lanes_ok(ADC0_1, ADC0_0)) begin : g_bad_cfg
      $error("tla_merge_unpack: ADC0_1 must be a non-zero multiple of ADC0_0");
   end
   state_t              state_q, state_d;
   logic                hold_v, done_q;
   logic [LW-1:0]       lane;
   logic [LDD0_0-1:0]   remaining;
   logic [ADC0_1-1:0]   hold;
   logic [ADC0_0-1:0]   samples [LANES];
   logic                run, hs, acc, wrap, last_smp;
   assign run           = state_q == RUN;
   assign wrap          = lane == LANE_MAX;
   assign last_smp      = remaining == LDD0_0'(1);
   assign Gc_merge_datr = run & (!hold_v | (wrap & Gc_smp_ready & !last_smp));
   assign Gc_smp_valid  = run & hold_v;
   assign Gc_smp_last   = Gc_smp_valid & last_smp;
   assign Gc_cap_busy   = run;
   assign Gc_cap_done   = done_q;
   assign hs            = Gc_smp_valid & Gc_smp_ready;
   assign acc           = Gc_merge_datr & Gc_merge_datv;
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign samples[l] = hold[l*ADC0_0 +: ADC0_0];
   end
   assign Gc_smp_data = samples[lane];
   // state register
   always_ff @(posedge Gc_clk125 or negedge Gc_rst) begin
      if (!Gc_rst) state_q <= IDLE;
      else         state_q <= state_d;
   end
   // next state: abort wins over the final handshake; start only counts from IDLE
   always_comb begin
      state_d = state_q;
      if (run) state_d = (Gc_cap_abort | (hs & last_smp)) ? IDLE : RUN;
      else     state_d = (Gc_cap_start & |Gc_cap_len) ? RUN : IDLE;
   end
   // holding register, lane pointer, sample countdown and done pulse
   always_ff @(posedge Gc_clk125 or negedge Gc_rst) begin
      if (!Gc_rst) begin
         hold      <= '0;
         hold_v    <= 1'b0;
         lane      <= '0;
         remaining <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= run ? (hs & last_smp & !Gc_cap_abort) : (Gc_cap_start & ~|Gc_cap_len);
         if (!run) begin
            if (Gc_cap_start) remaining <= Gc_cap_len;
         end else if (Gc_cap_abort) begin
            hold      <= '0;
            hold_v    <= 1'b0;
            lane      <= '0;
            remaining <= '0;
         end else begin
            if (hs) begin
               remaining <= remaining - LDD0_0'(1);
               lane      <= (wrap | last_smp) ? '0 : lane + LW'(1);
            end
            if (acc) begin
               hold   <= Gc_merge_data;
               hold_v <= 1'b1;
            end else if (hs & (wrap | last_smp)) begin
               hold_v <= 1'b0;
            end
         end
      end
   end
endmodule
